key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, prefix-state timeout in clk cycles (10 ms at 100 MHz).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 keycode_in  in  16  scan-code bytes from PS/2 receiver; [7:0] newest byte, [15:8] previous byte (ignored).
REQ-006 keycode_valid_in  in  1  one-cycle pulse: keycode_in[7:0] holds a new byte.
REQ-007 event_rd  in  1  pop head event.
REQ-008 event_data  out  10  head event {brk, ext, code[7:0]}.
REQ-009 event_valid  out  1  FIFO non-empty; event_data meaningful.
REQ-010 event_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 ovf  out  1  sticky: event dropped due to full FIFO.
REQ-012 seq_err  out  1  sticky: prefix timeout occurred.
REQ-013 flags_clr  in  1  clears ovf and seq_err.
REQ-014 mods  out  4  {alt, ctrl, rshift, lshift} held-key state (see Configuration).

Function
REQ-015 Decoder FSM states IDLE, GOT_E0, GOT_F0, GOT_E0F0; byte B sampled only when keycode_valid_in=1.
REQ-016 IDLE: B=E0 -> GOT_E0; B=F0 -> GOT_F0; B in {00, AA, E1, FA, FE, FF} -> discarded, stay IDLE; else emit {0,0,B}.
REQ-017 GOT_E0: B=F0 -> GOT_E0F0; B=E0 -> stay; else emit {0,1,B}, -> IDLE.
REQ-018 GOT_F0: B in {E0, F0} -> stay GOT_F0; else emit {1,0,B}, -> IDLE.
REQ-019 GOT_E0F0: B in {E0, F0} -> stay; else emit {1,1,B}, -> IDLE.
REQ-020 Emit = FIFO push on the clock edge that samples B; event_valid rises the next cycle (latency 1).
REQ-021 Timeout counter resets on every sampled byte; counts only in non-IDLE states; reaching TIMEOUT_CYCLES -> IDLE, seq_err=1, no event.
REQ-022 FIFO first-word fall-through: event_data always shows head; event_rd with event_valid=1 pops at that edge.
REQ-023 event_rd with event_valid=0 ignored; count never underflows.
REQ-024 Push when full and no pop: event dropped, ovf=1, FIFO contents unchanged.
REQ-025 Simultaneous push and pop when full: both performed, count unchanged, no ovf.
REQ-026 Simultaneous push and pop when empty: push performed, pop ignored, count 1.
REQ-027 flags_clr same cycle as new ovf/seq_err set event: set wins.
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 rst=1: FSM IDLE, timeout counter 0, FIFO empty, event_valid=0, event_count=0, event_data=0, ovf=0, seq_err=0, mods=0.
REQ-030 rst mid-prefix discards partial sequence; inputs ignored while rst=1.

Configuration
REQ-031 Macro KEY_EVENT_MODS_EN defined: on each emitted event (including dropped ones), code 12 -> lshift, 59 -> rshift, 14 -> ctrl (ext ignored), 11 -> alt (ext ignored); make sets bit, break clears it.
REQ-032 Macro undefined: mods tied to 4'b0000, no modifier logic present.

Verification
REQ-033 Bytes 1C -> event {0,0,1C}, event_valid next cycle, event_count 1.
REQ-034 Bytes E0,F0,74 -> single event {1,1,74}; bytes AA, FA -> no event.
REQ-035 Push FIFO_DEPTH+1 events (1C..) with no reads -> count 8, ovf=1, head still first event; flags_clr -> ovf=0.
REQ-036 Full FIFO, push 2B with event_rd same cycle -> count stays 8, ovf=0, 2B at tail.
REQ-037 Byte F0 then idle TIMEOUT_CYCLES -> seq_err=1, FSM IDLE; next byte 1C -> {0,0,1C}.
REQ-038 KEY_EVENT_MODS_EN: 12, E0 14 -> mods=0101; F0 12 -> mods=0100; rst mid E0 -> mods=0000, FSM IDLE.

Source files
------------

// File: rtl/key_event_ctrl.sv
// PS/2 scan-code decoder: turns E0/F0 prefixed byte streams into {brk, ext, code} events queued in a FWFT FIFO.
// Optional held-modifier tracking is compiled in with `define KEY_EVENT_MODS_EN.
module key_event_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [15:0]                      keycode_in,
    input  logic                             keycode_valid_in,
    input  logic                             event_rd,
    output logic [9:0]                       event_data,
    output logic                             event_valid,
    output logic [$clog2(FIFO_DEPTH):0]      event_count,
    output logic                             ovf,
    output logic                             seq_err,
    input  logic                             flags_clr,
    output logic [3:0]                       mods
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   to_cnt;
    logic [7:0]      byte_in;
    logic            unused_prev_byte;
    logic            is_e0;
    logic            is_f0;
    logic            is_junk;
    logic            emit_c;
    logic [EW-1:0]   ev_c;
    logic            timeout_c;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nx;
    logic [CW-1:0]   count_nx;
    logic [EW-1:0]   head_nx;
    logic            full;
    logic            pop_ok;
    logic            push_ok;
    logic            drop_c;

    assign byte_in          = keycode_in[7:0];
    assign unused_prev_byte = ^keycode_in[15:8];
    assign is_e0            = (byte_in == 8'hE0);
    assign is_f0            = (byte_in == 8'hF0);
    assign is_junk          = (byte_in == 8'h00) || (byte_in == 8'hAA) || (byte_in == 8'hE1) ||
                              (byte_in == 8'hFA) || (byte_in == 8'hFE) || (byte_in == 8'hFF);

    // Event decode for the byte sampled this edge; the push happens on the same edge.
    always_comb begin
        emit_c = 1'b0;
        ev_c   = {2'b00, byte_in};
        if (keycode_valid_in) begin
            case (state)
                IDLE: begin
                    emit_c = !is_e0 && !is_f0 && !is_junk;
                    ev_c   = {2'b00, byte_in};
                end
                GOT_E0: begin
                    emit_c = !is_e0 && !is_f0;
                    ev_c   = {2'b01, byte_in};
                end
                GOT_F0: begin
                    emit_c = !is_e0 && !is_f0;
                    ev_c   = {2'b10, byte_in};
                end
                GOT_E0F0: begin
                    emit_c = !is_e0 && !is_f0;
                    ev_c   = {2'b11, byte_in};
                end
                default: begin
                    emit_c = 1'b0;
                    ev_c   = {2'b00, byte_in};
                end
            endcase
        end
    end

    // A byte arriving on the expiry edge takes priority and restarts the window.
    assign timeout_c = !keycode_valid_in && (state != IDLE) &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Prefix FSM, timeout counter and sticky sequence-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            to_cnt  <= '0;
            seq_err <= 1'b0;
        end else begin
            if (keycode_valid_in) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (is_e0)      state <= GOT_E0;
                        else if (is_f0) state <= GOT_F0;
                        else            state <= IDLE;
                    end
                    GOT_E0: begin
                        if (is_f0)      state <= GOT_E0F0;
                        else if (is_e0) state <= GOT_E0;
                        else            state <= IDLE;
                    end
                    GOT_F0: begin
                        if (is_e0 || is_f0) state <= GOT_F0;
                        else                state <= IDLE;
                    end
                    GOT_E0F0: begin
                        if (is_e0 || is_f0) state <= GOT_E0F0;
                        else                state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout_c) begin
                state  <= IDLE;
                to_cnt <= '0;
            end else if (state != IDLE) begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (timeout_c)      seq_err <= 1'b1;
            else if (flags_clr) seq_err <= 1'b0;
        end
    end

    assign full    = (event_count == CW'(FIFO_DEPTH));
    assign pop_ok  = event_rd && event_valid;
    assign push_ok = emit_c && (!full || pop_ok);
    assign drop_c  = emit_c && !push_ok;
    assign rd_nx   = pop_ok ? (rd_ptr + AW'(1)) : rd_ptr;

    always_comb begin
        count_nx = event_count;
        case ({push_ok, pop_ok})
            2'b10:   count_nx = event_count + CW'(1);
            2'b01:   count_nx = event_count - CW'(1);
            default: count_nx = event_count;
        endcase
    end

    // Next head: the entry being written this edge if it lands at the new read slot.
    always_comb begin
        head_nx = '0;
        if (count_nx != '0) begin
            if (push_ok && (wr_ptr == rd_nx)) head_nx = ev_c;
            else                              head_nx = mem[rd_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= ev_c;
    end

    // FIFO pointers, registered head/valid/count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            event_count <= '0;
            event_valid <= 1'b0;
            event_data  <= '0;
            ovf         <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_nx;
            event_count <= count_nx;
            event_valid <= (count_nx != '0);
            event_data  <= head_nx;
            if (drop_c)         ovf <= 1'b1;
            else if (flags_clr) ovf <= 1'b0;
        end
    end

`ifdef KEY_EVENT_MODS_EN
    // Modifier state follows every decoded event, including those the FIFO drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mods <= 4'b0000;
        end else if (emit_c) begin
            if (ev_c[7:0] == 8'h12 && !ev_c[8]) mods[0] <= !ev_c[9];
            if (ev_c[7:0] == 8'h59 && !ev_c[8]) mods[1] <= !ev_c[9];
            if (ev_c[7:0] == 8'h14)             mods[2] <= !ev_c[9];
            if (ev_c[7:0] == 8'h11)             mods[3] <= !ev_c[9];
        end
    end
`else
    assign mods = 4'b0000;
`endif

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: decode, FIFO boundaries, timeout, flags and reset behaviour.
module tb_key_event_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 40;

`ifdef KEY_EVENT_MODS_EN
    localparam logic [3:0] MODS_A = 4'b0101;
    localparam logic [3:0] MODS_B = 4'b0100;
`else
    localparam logic [3:0] MODS_A = 4'b0000;
    localparam logic [3:0] MODS_B = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keycode_in;
    logic        keycode_valid_in;
    logic        event_rd;
    logic        flags_clr;
    logic [9:0]  event_data;
    logic        event_valid;
    logic [3:0]  event_count;
    logic        ovf;
    logic        seq_err;
    logic [3:0]  mods;

    int n_tests = 0;
    int n_fail  = 0;

    key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .keycode_in       (keycode_in),
        .keycode_valid_in (keycode_valid_in),
        .event_rd         (event_rd),
        .event_data       (event_data),
        .event_valid      (event_valid),
        .event_count      (event_count),
        .ovf              (ovf),
        .seq_err          (seq_err),
        .flags_clr        (flags_clr),
        .mods             (mods)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        keycode_in       = {8'hA5, b};
        keycode_valid_in = 1'b1;
        tick();
        keycode_valid_in = 1'b0;
    endtask

    task automatic pop();
        event_rd = 1'b1;
        tick();
        event_rd = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        keycode_in       = 16'h0000;
        keycode_valid_in = 1'b0;
        event_rd         = 1'b0;
        flags_clr        = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(event_valid), 32'h0);
        check("rst_count", 32'(event_count), 32'h0);
        check("rst_data",  32'(event_data),  32'h0);
        check("rst_ovf",   32'(ovf),         32'h0);
        check("rst_seq",   32'(seq_err),     32'h0);
        check("rst_mods",  32'(mods),        32'h0);
        rst = 1'b0;
        tick();

        // Plain make code
        send(8'h1C);
        check("mk_valid", 32'(event_valid), 32'h1);
        check("mk_data",  32'(event_data),  32'h01C);
        check("mk_count", 32'(event_count), 32'h1);
        pop();
        check("pop_valid", 32'(event_valid), 32'h0);
        check("pop_count", 32'(event_count), 32'h0);
        pop();
        check("pop_empty_count", 32'(event_count), 32'h0);

        // Extended break, then discarded bytes
        send(8'hE0);
        send(8'hF0);
        check("pfx_noevt", 32'(event_valid), 32'h0);
        send(8'h74);
        check("xbrk_data",  32'(event_data),  32'h374);
        check("xbrk_count", 32'(event_count), 32'h1);
        send(8'hAA);
        send(8'hFA);
        check("junk_count", 32'(event_count), 32'h1);
        pop();

        // Overflow: nine pushes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) send(8'h1C + 8'(i));
        check("ovf_count", 32'(event_count), 32'h8);
        check("ovf_flag",  32'(ovf),         32'h1);
        check("ovf_head",  32'(event_data),  32'h01C);
        flags_clr = 1'b1;
        send(8'h25);
        flags_clr = 1'b0;
        check("ovf_setwins", 32'(ovf), 32'h1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'h0);

        // Push and pop together while full
        event_rd = 1'b1;
        send(8'h2B);
        event_rd = 1'b0;
        check("fullpp_count", 32'(event_count), 32'h8);
        check("fullpp_ovf",   32'(ovf),         32'h0);
        for (int i = 0; i < 7; i++) begin
            check("drain_head", 32'(event_data), 32'h01D + 32'(i));
            pop();
        end
        check("tail_data",  32'(event_data),  32'h02B);
        check("tail_count", 32'(event_count), 32'h1);
        pop();
        check("drained", 32'(event_valid), 32'h0);

        // Prefix timeout
        send(8'hF0);
        repeat (TO - 1) tick();
        check("to_before", 32'(seq_err), 32'h0);
        tick();
        check("to_after", 32'(seq_err),     32'h1);
        check("to_noevt", 32'(event_valid), 32'h0);
        send(8'h1C);
        check("to_idle_data", 32'(event_data), 32'h01C);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("seq_clr", 32'(seq_err), 32'h0);
        pop();

        // Push and pop together while empty
        event_rd = 1'b1;
        send(8'h3A);
        event_rd = 1'b0;
        check("emptypp_count", 32'(event_count), 32'h1);
        check("emptypp_data",  32'(event_data),  32'h03A);
        pop();

        // Repeated E0 stays in extended prefix
        send(8'hE0);
        send(8'hE0);
        send(8'h5A);
        check("e0e0_data", 32'(event_data), 32'h15A);
        pop();

        // Modifiers and reset mid-prefix
        send(8'h12);
        send(8'hE0);
        send(8'h14);
        check("mods_a",   32'(mods),       32'(MODS_A));
        check("rctl_evt", 32'(event_data), 32'h012);
        send(8'hF0);
        send(8'h12);
        check("mods_b", 32'(mods),        32'(MODS_B));
        check("mods_n", 32'(event_count), 32'h3);
        send(8'hE0);
        rst = 1'b1;
        send(8'h77);
        rst = 1'b0;
        check("rst2_mods",  32'(mods),        32'h0);
        check("rst2_count", 32'(event_count), 32'h0);
        send(8'h14);
        check("rst2_idle", 32'(event_data), 32'h014);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
